piso: RTL and testbench

4-bit-default parallel-in serial-out shift register. It is the transmit-side counterpart of the team's serial-in parallel-out deserializer.
- Accepts parallel words over a valid/ready handshake and buffers one word in a holding register.
- Serializes each word MSB-first with per-bit valid and start-of-frame strobes.
- Sits between a word-producing block and a serial link or deserializer.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso.sv | 104 ++++++++++
 tb/tb_piso.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out shifter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   localparam int unsigned PISO_DEF_WIDTH = 4;

   // Bit-counter width; never narrower than one bit.
   function automatic int unsigned piso_cnt_width(input int unsigned width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out shifter with a one-word holding register in front.
// Words enter on a valid/ready handshake, are serialized with per-bit valid and
// start-of-frame strobes, and stream gaplessly when the next word is already held.
module piso
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = PISO_DEF_WIDTH,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_valid_i,
   output logic             load_ready_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             shift_en_i,
   output logic             data_o,
   output logic             valid_o,
   output logic             sof_o,
   output logic             busy_o
);

   localparam int unsigned    CW       = piso_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   piso_state_t      r_state, w_state_next;
   logic [WIDTH-1:0] r_sr, w_sr_next;
   logic [CW-1:0]    r_cnt, w_cnt_next;
   logic [WIDTH-1:0] r_hold, w_hold_next;
   logic             r_hold_full, w_hold_full_next;

   logic             w_accept;
   logic [WIDTH-1:0] w_sr_shifted;

   // Ready depends only on a flop, so there is no input-to-ready path.
   assign w_accept     = load_valid_i && !r_hold_full;
   assign w_sr_shifted = LSB_FIRST ? (r_sr >> 1) : (r_sr << 1);

   // Next-state: handshake into hold, hold->sr moves, and bit shifting.
   always_comb begin
      w_state_next     = r_state;
      w_sr_next        = r_sr;
      w_cnt_next       = r_cnt;
      w_hold_next      = r_hold;
      w_hold_full_next = r_hold_full;

      // Accept only happens with hold empty, so it never collides with a hold->sr move.
      if (w_accept) begin
         w_hold_next      = data_i;
         w_hold_full_next = 1'b1;
      end

      unique case (r_state)
         IDLE: begin
            if (r_hold_full) begin
               w_sr_next        = r_hold;
               w_cnt_next       = '0;
               w_hold_full_next = 1'b0;
               w_state_next     = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en_i) begin
               if (r_cnt != LAST_CNT) begin
                  w_sr_next  = w_sr_shifted;
                  w_cnt_next = r_cnt + 1'b1;
               end else if (r_hold_full) begin
                  // Back-to-back word: reload without leaving SHIFT.
                  w_sr_next        = r_hold;
                  w_cnt_next       = '0;
                  w_hold_full_next = 1'b0;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State registers; reset discards any partial word and the held word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE;
         r_sr        <= '0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sr        <= w_sr_next;
         r_cnt       <= w_cnt_next;
         r_hold      <= w_hold_next;
         r_hold_full <= w_hold_full_next;
      end
   end

   // Outputs decoded from flops only; data is forced low outside SHIFT.
   assign valid_o      = (r_state == SHIFT);
   assign data_o       = valid_o && (LSB_FIRST ? r_sr[0] : r_sr[WIDTH-1]);
   assign sof_o        = valid_o && (r_cnt == '0);
   assign busy_o       = valid_o || r_hold_full;
   assign load_ready_o = !r_hold_full;

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: default MSB-first 4-bit instance plus an
// 8-bit LSB-first instance sharing clock, reset and shift enable.
module tb_piso;

   logic       clk;
   logic       rst_n;
   logic       shift_en;

   logic       lv1, rdy1, d1_o, v1, sof1, busy1;
   logic [3:0] d1;

   logic       lv2, rdy2, d2_o, v2, sof2, busy2;
   logic [7:0] d2;

   int n_checks = 0;
   int n_errors = 0;

   piso #(.WIDTH(4), .LSB_FIRST(1'b0)) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .load_valid_i(lv1),
      .load_ready_o(rdy1),
      .data_i      (d1),
      .shift_en_i  (shift_en),
      .data_o      (d1_o),
      .valid_o     (v1),
      .sof_o       (sof1),
      .busy_o      (busy1)
   );

   piso #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .load_valid_i(lv2),
      .load_ready_o(rdy2),
      .data_i      (d2),
      .shift_en_i  (shift_en),
      .data_o      (d2_o),
      .valid_o     (v2),
      .sof_o       (sof2),
      .busy_o      (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic d, input logic s);
      chk({tag, ".valid"}, {31'd0, v1}, {31'd0, v});
      chk({tag, ".data"}, {31'd0, d1_o}, {31'd0, d});
      chk({tag, ".sof"}, {31'd0, sof1}, {31'd0, s});
   endtask

   initial begin
      logic [3:0]  s1;
      logic [7:0]  s2;
      logic [11:0] s4;
      logic [3:0]  s5;
      logic [7:0]  s6;
      logic [3:0]  words [3];
      int          widx;
      logic        acc;

      rst_n = 1'b0; shift_en = 1'b1;
      lv1 = 1'b1; d1 = 4'hF; lv2 = 1'b0; d2 = 8'h00;

      // Reset state, with a load presented during reset that must be ignored.
      step();
      step();
      chk_out("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.busy", {31'd0, busy1}, 32'd0);
      chk("rst.ready", {31'd0, rdy1}, 32'd1);
      lv1 = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst.busy", {31'd0, busy1}, 32'd0);

      // 1: single word 4'hA, shift_en high.
      s1 = 4'b1010;
      lv1 = 1'b1; d1 = 4'hA;
      step();
      chk("t1.ready_after_accept", {31'd0, rdy1}, 32'd0);
      chk("t1.busy_after_accept", {31'd0, busy1}, 32'd1);
      chk("t1.valid_before_move", {31'd0, v1}, 32'd0);
      lv1 = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("t1.bit%0d", i), 1'b1, s1[3-i], i == 0);
         step();
      end
      chk_out("t1.end", 1'b0, 1'b0, 1'b0);
      chk("t1.busy_end", {31'd0, busy1}, 32'd0);

      // 2: 4'hA then 4'h5 streamed back to back.
      s2 = 8'b1010_0101;
      lv1 = 1'b1; d1 = 4'hA;
      step();
      d1 = 4'h5;
      step();
      chk_out("t2.bit0", 1'b1, s2[7], 1'b1);
      chk("t2.ready_bit0", {31'd0, rdy1}, 32'd1);
      step();
      lv1 = 1'b0;
      chk_out("t2.bit1", 1'b1, s2[6], 1'b0);
      chk("t2.ready_hold_full", {31'd0, rdy1}, 32'd0);
      for (int i = 2; i < 8; i++) begin
         step();
         chk_out($sformatf("t2.bit%0d", i), 1'b1, s2[7-i], i == 4);
         if (i == 3) chk("t2.ready_bit3", {31'd0, rdy1}, 32'd0);
         if (i == 4) chk("t2.ready_after_reload", {31'd0, rdy1}, 32'd1);
      end
      step();
      chk_out("t2.end", 1'b0, 1'b0, 1'b0);

      // 3: 4'h9 with shift_en alternating; each bit held two cycles.
      s1 = 4'b1001;
      shift_en = 1'b0;
      lv1 = 1'b1; d1 = 4'h9;
      step();
      lv1 = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("t3.bit%0d_a", i), 1'b1, s1[3-i], i == 0);
         shift_en = 1'b0;
         step();
         chk_out($sformatf("t3.bit%0d_b", i), 1'b1, s1[3-i], i == 0);
         shift_en = 1'b1;
         step();
      end
      chk_out("t3.end", 1'b0, 1'b0, 1'b0);

      // 4: three words with load_valid held high; stream must be 0001 0010 0011.
      s4 = 12'b0001_0010_0011;
      words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
      widx = 0;
      lv1 = 1'b1; d1 = words[0];
      for (int k = 0; k <= 13; k++) begin
         acc = lv1 && rdy1;
         step();
         if (acc) begin
            widx++;
            if (widx < 3) d1 = words[widx];
            else lv1 = 1'b0;
         end
         if (k == 6) chk("t4.third_accept_edge", widx, 32'd3);
         if (k == 5) chk("t4.two_accepted_before", widx, 32'd2);
         if (k >= 1 && k <= 12)
            chk_out($sformatf("t4.bit%0d", k - 1), 1'b1, s4[12-k], ((k - 1) % 4) == 0);
      end
      chk_out("t4.end", 1'b0, 1'b0, 1'b0);
      chk("t4.words_accepted", widx, 32'd3);

      // 5: reset mid-word, then a clean word afterwards.
      lv1 = 1'b1; d1 = 4'hC;
      step();
      lv1 = 1'b0;
      step();
      chk_out("t5.bit0", 1'b1, 1'b1, 1'b1);
      step();
      step();
      chk_out("t5.bit2", 1'b1, 1'b0, 1'b0);
      lv1 = 1'b1; d1 = 4'hF;
      #2 rst_n = 1'b0;
      #1;
      chk_out("t5.in_rst", 1'b0, 1'b0, 1'b0);
      chk("t5.busy_in_rst", {31'd0, busy1}, 32'd0);
      chk("t5.ready_in_rst", {31'd0, rdy1}, 32'd1);
      step();
      lv1 = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      chk_out("t5.no_residual", 1'b0, 1'b0, 1'b0);
      chk("t5.busy_after_rst", {31'd0, busy1}, 32'd0);
      s5 = 4'b0011;
      lv1 = 1'b1; d1 = 4'h3;
      step();
      lv1 = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk_out($sformatf("t5.bit%0d_new", i), 1'b1, s5[3-i], i == 0);
         step();
      end
      chk_out("t5.end", 1'b0, 1'b0, 1'b0);

      // 6: LSB-first, WIDTH=8, 8'hA5 -> 1,0,1,0,0,1,0,1.
      s6 = 8'b1010_0101;
      lv2 = 1'b1; d2 = 8'hA5;
      step();
      lv2 = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t6.bit%0d.valid", i), {31'd0, v2}, 32'd1);
         chk($sformatf("t6.bit%0d.data", i), {31'd0, d2_o}, {31'd0, s6[7-i]});
         chk($sformatf("t6.bit%0d.sof", i), {31'd0, sof2}, {31'd0, i == 0});
         step();
      end
      chk("t6.end.valid", {31'd0, v2}, 32'd0);
      chk("t6.end.busy", {31'd0, busy2}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
